clock_divider_bank: RTL and testbench
=====================================

# clock_divider_bank

- Parametrised successor to the fixed-ratio clock/strobe generator.
- Produces `N_CH` independent 50%-duty divided clocks and one-cycle rising-edge strobes from the 100 MHz system clock.
- Each channel's half-period is reprogrammable at runtime through a valid/ready config port, and new ratios apply only on period boundaries, so output periods are never glitched.
- A global sync strobe phase-aligns all channels, for example DUT clock against ADC sampling clock.

## Interface
- `N_CH`, 2: number of divider channels (1..16).
- `CH_W`, 1: width of channel select; must satisfy 2^CH_W ≥ N_CH.
- `DIV_W`, 8: width of half-period value.
- `DEFAULT_HALF`, 2: half-period loaded into every channel at reset (2 gives 25 MHz from 100 MHz).
- `clk_in`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config can be accepted; combinational from `cfg_ch` and pending state.
- `cfg_ch`  in  CH_W  target channel.
- `cfg_half`  in  DIV_W  new half-period in clk_in cycles; 0 disables the channel.
- `cfg_err`  out  1  one-cycle pulse: an accepted request had `cfg_ch` ≥ N_CH.
- `sync_in`  in  1  phase-align all channels.
- `div_clk`  out  N_CH  divided clocks (registered).
- `rise_stb`  out  N_CH  one-cycle pulse in the first high cycle of each `div_clk` period.
- `busy`  out  N_CH  channel holds a pending, not yet applied half-period.

## Operation
- Per-channel state:
  - `half` (DIV_W)
  - `cnt` (DIV_W)
  - `pend` value plus `pend_v` flag
  - `div_clk` bit
- Reset values: `half`=DEFAULT_HALF, `cnt`=0, `pend_v`=0, `div_clk`=0, `rise_stb`=0, `cfg_err`=0. `busy` equals `pend_v`.
- Counting when `half` ≠ 0:
  - If `cnt` == `half`-1: toggle `div_clk` and set `cnt`=0.
  - Otherwise: `cnt`+1.
  - Period is 2·half cycles with exact 50% duty.
- Channel with `half`=0 is disabled: `div_clk`=0, `cnt`=0, no strobes.
- `cfg_ready` = !`pend_v[cfg_ch]` when `cfg_ch` < N_CH; it is 1 when `cfg_ch` ≥ N_CH.
- Accept = `cfg_valid` & `cfg_ready` on a clock edge.
  - Valid channel: sets `pend`=`cfg_half`, `pend_v`=1.
  - Out-of-range channel: request is dropped, and `cfg_err`=1 for the next cycle.
- Applying the pending value (clears `pend_v`):
  - Running channel: at the edge where `div_clk` would go 0→1 (end of low phase).
    - If new half ≠ 0: `div_clk` goes 1, `half`=pend, `cnt`=0, and the high phase lasts the new half.
    - If new half = 0: `div_clk` stays 0 and the channel disables; no `rise_stb` is issued.
  - Disabled channel: at the first edge after acceptance, with `cnt`=0 and `div_clk`=0. The first rise follows after `half` further edges.
  - A pending value is never applied during the high phase.
- `sync_in` high at an edge, for every channel:
  - `cnt`=0, `div_clk`=0, `rise_stb`=0.
  - If `pend_v`: `half`=pend and `pend_v`=0.
  - A config accepted in the same cycle as `sync_in` is applied immediately by the sync.
- Accept on the same edge as the channel's apply edge: `cfg_ready` was 1, so there was nothing to apply. The edge uses the old `half`, and the new value becomes pending.
- Priority: `rst` > `sync_in` > apply/count.

## Timing
- Latency: all outputs are registered; `cfg_ready` is the only combinational output.
- Count edges from the first edge with `rst`=0 as edge 1. After reset or sync, a channel with half H:
  - `div_clk`=1 after edge H, 0 after edge 2H, 1 after edge 3H, and so on.
  - `rise_stb`=1 after edges H, 3H, 5H, …, each for exactly one cycle.
- H=1 gives `div_clk` = clk_in/2, with `rise_stb` high every other cycle.
- Max half = 2^DIV_W−1. Widths never overflow because `cnt` < `half`.
- Reset mid-operation: all state returns to reset values on that edge, and pending configs are discarded.

## Test plan
- Reset, N_CH=2, DEFAULT_HALF=2, run 20 cycles → both `div_clk` toggle after edges 2, 4, 6, …; `rise_stb` high after edges 2, 6, 10, 14, 18.
- Load ch1 half=5 while ch1 is in its high phase → `busy[1]`=1; the old period finishes; the next rise starts 10-cycle periods; `cfg_ready` is low for ch1 while pending; a second request to ch1 stalls until applied.
- Load ch0 half=0, then half=3 → ch0 goes low at the end of its low phase and stays 0 with no strobes; after the half=3 accept, the first rise comes 3 edges after apply.
- Assert `sync_in` with ch0 half=2 and ch1 half=5 mid-period → both outputs are 0 next cycle; rises after 2 and 5 edges; a config accepted in the sync cycle takes effect immediately.
- `cfg_ch`=3 with N_CH=2 → `cfg_ready`=1, request accepted, `cfg_err` pulses for 1 cycle, no channel state changes.
- Assert `rst` while ch1 has a pending config and `div_clk` high → all outputs are 0 and `busy`=0 next cycle; DEFAULT_HALF timing resumes.

Source files
------------

// File: rtl/clock_divider_bank.sv
// N_CH independent 50%-duty clock dividers with rise strobes, runtime half-period reprogramming and global sync.
// Outputs registered (1 cycle); cfg_ready combinational, low while the selected channel holds a pending half-period.
module clock_divider_bank #(
    parameter int N_CH         = 2,
    parameter int CH_W         = 1,
    parameter int DIV_W        = 8,
    parameter int DEFAULT_HALF = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_half,
    output logic              cfg_err,
    input  logic              sync_in,
    output logic [N_CH-1:0]   div_clk,
    output logic [N_CH-1:0]   rise_stb,
    output logic [N_CH-1:0]   busy
);

    logic [DIV_W-1:0] r_half [N_CH];
    logic [DIV_W-1:0] r_cnt  [N_CH];
    logic [DIV_W-1:0] r_pend [N_CH];
    logic [N_CH-1:0]  r_pend_v;
    logic [N_CH-1:0]  r_div;
    logic [N_CH-1:0]  r_stb;
    logic             r_err;

    logic [N_CH-1:0]  w_hit;
    logic             w_in_range;
    logic             w_accept;

    // One-hot channel decode; an all-zero result means cfg_ch is out of range.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_hit
        assign w_hit[gi] = (cfg_ch == CH_W'(gi));
    end

    assign w_in_range = |w_hit;
    assign cfg_ready  = w_in_range ? ~|(w_hit & r_pend_v) : 1'b1;
    assign w_accept   = cfg_valid & cfg_ready;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_half[i] <= DIV_W'(DEFAULT_HALF);
                r_cnt[i]  <= '0;
                r_pend[i] <= '0;
            end
            r_pend_v <= '0;
            r_div    <= '0;
            r_stb    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_in_range;
            for (int i = 0; i < N_CH; i++) begin
                if (sync_in) begin
                    r_cnt[i]    <= '0;
                    r_div[i]    <= 1'b0;
                    r_stb[i]    <= 1'b0;
                    r_pend_v[i] <= 1'b0;
                    // A request arriving with the sync bypasses the pending slot.
                    if (w_accept && w_hit[i])
                        r_half[i] <= cfg_half;
                    else if (r_pend_v[i])
                        r_half[i] <= r_pend[i];
                end else begin
                    r_stb[i] <= 1'b0;
                    if (r_half[i] == '0) begin
                        r_cnt[i] <= '0;
                        r_div[i] <= 1'b0;
                        if (r_pend_v[i]) begin
                            r_half[i]   <= r_pend[i];
                            r_pend_v[i] <= 1'b0;
                        end
                    end else if (r_cnt[i] == r_half[i] - 1'b1) begin
                        r_cnt[i] <= '0;
                        // New ratio lands only where a rising edge would start a period.
                        if (!r_div[i] && r_pend_v[i]) begin
                            r_half[i]   <= r_pend[i];
                            r_pend_v[i] <= 1'b0;
                            r_div[i]    <= (r_pend[i] != '0);
                            r_stb[i]    <= (r_pend[i] != '0);
                        end else begin
                            r_div[i] <= ~r_div[i];
                            r_stb[i] <= ~r_div[i];
                        end
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                    if (w_accept && w_hit[i]) begin
                        r_pend[i]   <= cfg_half;
                        r_pend_v[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign div_clk  = r_div;
    assign rise_stb = r_stb;
    assign busy     = r_pend_v;
    assign cfg_err  = r_err;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: table-driven vectors with a scoreboard queue of expected post-edge outputs.
// Expected waveforms derive from the edge-numbered timing of each channel after reset, sync or reprogramming.
module tb_clock_divider_bank;

    localparam int N_CH  = 2;
    localparam int CH_W  = 2;
    localparam int DIV_W = 8;

    logic              clk_in = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_half;
    logic              cfg_err;
    logic              sync_in;
    logic [N_CH-1:0]   div_clk;
    logic [N_CH-1:0]   rise_stb;
    logic [N_CH-1:0]   busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       vld;
        logic [1:0] ch;
        logic [7:0] half;
        logic       sync;
        logic       chk_rdy;
        logic       rdy;
        logic [1:0] div;
        logic [1:0] stb;
        logic [1:0] bsy;
        logic       err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk_in = ~clk_in;

    clock_divider_bank #(
        .N_CH(N_CH), .CH_W(CH_W), .DIV_W(DIV_W), .DEFAULT_HALF(2)
    ) dut (
        .clk_in(clk_in), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_err(cfg_err), .sync_in(sync_in),
        .div_clk(div_clk), .rise_stb(rise_stb), .busy(busy)
    );

    // Half=2 channel, j edges after reset/sync: high after edges 2,3,6,7,...; rise at 2,6,10,...
    function automatic logic dd(input int j);
        return (j >= 1) && j[1];
    endfunction

    function automatic logic ds(input int j);
        return (j >= 1) && ((j % 4) == 2);
    endfunction

    function automatic vec_t mkv(input logic [1:0] div, input logic [1:0] stb, input logic [1:0] bsy);
        vec_t v;
        v.vld = 1'b0; v.ch = 2'd0; v.half = 8'd0; v.sync = 1'b0;
        v.chk_rdy = 1'b0; v.rdy = 1'b1;
        v.div = div; v.stb = stb; v.bsy = bsy; v.err = 1'b0;
        return v;
    endfunction

    function automatic vec_t with_cfg(input vec_t vi, input logic [1:0] ch, input logic [7:0] half, input logic rdy);
        vec_t v;
        v = vi;
        v.vld = 1'b1; v.ch = ch; v.half = half; v.chk_rdy = 1'b1; v.rdy = rdy;
        return v;
    endfunction

    task automatic idle_inputs();
        cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0; sync_in = 1'b0;
    endtask

    task automatic chk_reset(input string nm);
        checks++;
        if ({div_clk, rise_stb, busy, cfg_err, cfg_ready} !== 8'b0000_0000_1) begin
            failures++;
            $display("FAIL %s: div=%b stb=%b busy=%b err=%b rdy=%b, required all 0 and rdy=1",
                     nm, div_clk, rise_stb, busy, cfg_err, cfg_ready);
        end
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk_in);
        #1;
        chk_reset(nm);
        rst = 1'b0;
    endtask

    task automatic run_tbl(input string nm);
        vec_t v;
        vec_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            cfg_valid = v.vld; cfg_ch = v.ch; cfg_half = v.half; sync_in = v.sync;
            #1;
            if (v.chk_rdy) begin
                checks++;
                if (cfg_ready !== v.rdy) begin
                    failures++;
                    $display("FAIL %s_rdy edge %0d: cfg_ready=%b required %b", nm, i + 1, cfg_ready, v.rdy);
                end
            end
            exp_q.push_back(v);
            @(posedge clk_in);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({div_clk, rise_stb, busy, cfg_err} !== {e.div, e.stb, e.bsy, e.err}) begin
                failures++;
                $display("FAIL %s edge %0d: div=%b stb=%b busy=%b err=%b required div=%b stb=%b busy=%b err=%b",
                         nm, i + 1, div_clk, rise_stb, busy, cfg_err, e.div, e.stb, e.bsy, e.err);
            end
        end
        tbl.delete();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic d1, s1, b1, d0, s0, b0;
        idle_inputs();

        // Default timing after reset on both channels
        do_reset("reset_state");
        for (int k = 1; k <= 20; k++)
            tbl.push_back(mkv({2{dd(k)}}, {2{ds(k)}}, 2'b00));
        run_tbl("default");

        // ch1 reprogrammed to 5 during its high phase, second request stalls, then 7
        do_reset("reset_b");
        for (int k = 1; k <= 24; k++) begin
            d1 = (k >= 2 && k <= 3) || (k >= 6 && k <= 10) || (k >= 16 && k <= 22);
            s1 = (k == 2) || (k == 6) || (k == 16);
            b1 = (k >= 3 && k <= 5) || (k >= 7 && k <= 15);
            v = mkv({d1, dd(k)}, {s1, ds(k)}, {b1, 1'b0});
            if (k == 3) v = with_cfg(v, 2'd1, 8'd5, 1'b1);
            if (k >= 4 && k <= 6) v = with_cfg(v, 2'd1, 8'd7, 1'b0);
            if (k == 7) v = with_cfg(v, 2'd1, 8'd7, 1'b1);
            tbl.push_back(v);
        end
        run_tbl("reprog_ch1");

        // ch0 disabled via half=0, later re-enabled with half=3
        do_reset("reset_c");
        for (int k = 1; k <= 20; k++) begin
            d0 = (k >= 2 && k <= 3) || (k >= 12 && k <= 14) || (k >= 18);
            s0 = (k == 2) || (k == 12) || (k == 18);
            b0 = (k >= 3 && k <= 5) || (k == 8);
            v = mkv({dd(k), d0}, {ds(k), s0}, {1'b0, b0});
            if (k == 3) v = with_cfg(v, 2'd0, 8'd0, 1'b1);
            if (k == 8) v = with_cfg(v, 2'd0, 8'd3, 1'b1);
            tbl.push_back(v);
        end
        run_tbl("disable_ch0");

        // Sync mid-period, then sync together with a ch0 config
        do_reset("reset_d");
        for (int k = 1; k <= 28; k++) begin
            if (k <= 6) begin
                d0 = dd(k); s0 = ds(k);
            end else if (k <= 17) begin
                d0 = dd(k - 7); s0 = ds(k - 7);
            end else begin
                d0 = (k >= 21 && k <= 23) || (k >= 27);
                s0 = (k == 21) || (k == 27);
            end
            d1 = (k >= 2 && k <= 6) || (k >= 12 && k <= 16) || (k >= 23 && k <= 27);
            s1 = (k == 2) || (k == 12) || (k == 23);
            v = mkv({d1, d0}, {s1, s0}, {k == 1, 1'b0});
            if (k == 1) v = with_cfg(v, 2'd1, 8'd5, 1'b1);
            if (k == 7) v.sync = 1'b1;
            if (k == 18) begin
                v = with_cfg(v, 2'd0, 8'd3, 1'b1);
                v.sync = 1'b1;
            end
            tbl.push_back(v);
        end
        run_tbl("sync");

        // Out-of-range channel, then accept on an apply edge and half=1
        do_reset("reset_e");
        for (int k = 1; k <= 12; k++) begin
            if (k <= 5) begin
                d0 = dd(k); s0 = ds(k);
            end else begin
                d0 = ~k[0]; s0 = ~k[0];
            end
            v = mkv({dd(k), d0}, {ds(k), s0}, {1'b0, k >= 2 && k <= 5});
            if (k == 1) begin
                v = with_cfg(v, 2'd3, 8'd9, 1'b1);
                v.err = 1'b1;
            end
            if (k == 2) v = with_cfg(v, 2'd0, 8'd1, 1'b1);
            tbl.push_back(v);
        end
        run_tbl("oor_half1");

        // Reset while ch1 is high with a pending config
        do_reset("reset_f");
        for (int k = 1; k <= 3; k++) begin
            v = mkv({2{dd(k)}}, {2{ds(k)}}, {k == 3, 1'b0});
            if (k == 3) v = with_cfg(v, 2'd1, 8'd5, 1'b1);
            tbl.push_back(v);
        end
        run_tbl("pre_reset");
        rst = 1'b1;
        idle_inputs();
        @(posedge clk_in);
        #1;
        chk_reset("mid_reset");
        rst = 1'b0;
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mkv({2{dd(k)}}, {2{ds(k)}}, 2'b00));
        run_tbl("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
